// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds and one-cycle error pulses.
module fifo_sync_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             wr_error_o,
  output logic             rd_error_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr_acc, rd_acc;

  assign wr_acc  = wr_en_i & ~full_o;
  assign rd_acc  = rd_en_i & ~empty_o;
  // DEPTH is a power of two, so the carry out of the address lands in the wrap bit
  assign wr_nxt  = wr_ptr + (AW+1)'(wr_acc);
  assign rd_nxt  = rd_ptr + (AW+1)'(rd_acc);
  assign cnt_nxt = count_o + CNT_W'(wr_acc) - CNT_W'(rd_acc);

  always_ff @(posedge clk_i) begin
    if (clr_ni && wr_acc) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

  // Flags are loaded from next-state values so they move on the same edge as the pointers
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      wr_error_o     <= 1'b0;
      rd_error_o     <= 1'b0;
    end else begin
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      count_o        <= cnt_nxt;
      full_o         <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      empty_o        <= (wr_nxt == rd_nxt);
      almost_full_o  <= cnt_nxt >= CNT_W'(AFULL_THRESH);
      almost_empty_o <= cnt_nxt <= CNT_W'(AEMPTY_THRESH);
      wr_error_o     <= wr_en_i & full_o;
      rd_error_o     <= rd_en_i & empty_o;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk_i) begin
        if (!clr_ni)     rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem[rd_ptr[AW-1:0]];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// checks both against a queue-based model of the FIFO.
module tb_fifo_sync_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             gclk;
  logic             clr_n;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] s_rdata, f_rdata;
  logic             s_full, s_empty, s_afull, s_aempty, s_werr, s_rerr;
  logic             f_full, f_empty, f_afull, f_aempty, f_werr, f_rerr;
  logic [CNT_W-1:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_rd_std;
  logic             exp_werr, exp_rerr;

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
    .clk_i(gclk), .clr_ni(clr_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(s_rdata), .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_afull),
    .almost_empty_o(s_aempty), .count_o(s_count), .wr_error_o(s_werr), .rd_error_o(s_rerr)
  );

  fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk_i(gclk), .clr_ni(clr_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_afull),
    .almost_empty_o(f_aempty), .count_o(f_count), .wr_error_o(f_werr), .rd_error_o(f_rerr)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it
  task automatic step(input logic c, input logic w, input logic [WIDTH-1:0] d, input logic r);
    int n;
    clr_n = c; wr_en = w; wdata = d; rd_en = r;
    @(posedge gclk);
    if (!c) begin
      q.delete();
      exp_rd_std = '0;
      exp_werr   = 1'b0;
      exp_rerr   = 1'b0;
    end else begin
      n        = q.size();
      exp_werr = w && (n == DEPTH);
      exp_rerr = r && (n == 0);
      if (r && n != 0) exp_rd_std = q.pop_front();
      if (w && n != DEPTH) q.push_back(d);
    end
    #1;
    n = q.size();
    chk("std_count",  32'(s_count),  32'(n));
    chk("std_full",   32'(s_full),   32'(n == DEPTH));
    chk("std_empty",  32'(s_empty),  32'(n == 0));
    chk("std_afull",  32'(s_afull),  32'(n >= DEPTH - 2));
    chk("std_aempty", 32'(s_aempty), 32'(n <= 2));
    chk("std_werr",   32'(s_werr),   32'(exp_werr));
    chk("std_rerr",   32'(s_rerr),   32'(exp_rerr));
    chk("std_rdata",  32'(s_rdata),  32'(exp_rd_std));
    chk("fwft_count", 32'(f_count),  32'(n));
    chk("fwft_full",  32'(f_full),   32'(n == DEPTH));
    chk("fwft_empty", 32'(f_empty),  32'(n == 0));
    chk("fwft_afull", 32'(f_afull),  32'(n >= DEPTH - 2));
    chk("fwft_aempty",32'(f_aempty), 32'(n <= 2));
    chk("fwft_werr",  32'(f_werr),   32'(exp_werr));
    chk("fwft_rerr",  32'(f_rerr),   32'(exp_rerr));
    chk("fwft_rdata", 32'(f_rdata),  (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  initial begin
    clr_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    exp_rd_std = '0; exp_werr = 1'b0; exp_rerr = 1'b0;

    // reset, then idle
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);

    // fill 0x01..0x10, push against full, drain, pop against empty
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, WIDTH'(i), 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // hold count at 5 with concurrent traffic across several wraps
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, WIDTH'($urandom), 1'b1);
    while (q.size() != 0) step(1'b1, 1'b0, '0, 1'b1);

    // single word into empty FIFO, then pop
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // reset at count 9 with both requests active
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, WIDTH'(8'h80 + i), 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    step(1'b1, 1'b1, 8'h5B, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // random traffic with drifting write/read bias and occasional reset
    for (int blk = 0; blk < 20; blk++) begin
      int wp;
      wp = $urandom_range(20, 80);
      for (int i = 0; i < 100; i++)
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < wp),
             WIDTH'($urandom), ($urandom_range(0, 99) < 100 - wp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO that succeeds the basic 16x8 buffer. It adds selectable read mode (standard registered read or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, and same-edge flag update. It is used between producer/consumer stages in one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full_o asserted when count_o >= this value (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty_o asserted when count_o <= this value (0..DEPTH-1)
CNT_W, $clog2(DEPTH)+1, width of count_o (derived, not overridden)

Ports:
clk_i  in  1  clock; all logic on the rising edge
clr_ni  in  1  synchronous active-low reset
wr_en_i  in  1  write request
wdata_i  in  WIDTH  write data
rd_en_i  in  1  read request (in FWFT mode this pops the head word)
rdata_o  out  WIDTH  read data
full_o  out  1  FIFO holds DEPTH words
empty_o  out  1  FIFO holds 0 words
almost_full_o  out  1  count_o >= AFULL_THRESH
almost_empty_o  out  1  count_o <= AEMPTY_THRESH
count_o  out  CNT_W  current occupancy, 0..DEPTH
wr_error_o  out  1  one-cycle pulse: write rejected
rd_error_o  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset: on an edge with clr_ni=0, set pointers, wrap bits and count_o to 0. Set empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, wr_error_o=0, rd_error_o=0 and rdata_o=0. Memory contents are not cleared. Requests in a reset cycle are ignored and raise no error. Reset takes effect mid-operation the same way; all stored data is discarded.
- Pointers: address width is $clog2(DEPTH), plus one wrap bit per pointer.
  - full = addresses equal and wrap bits differ.
  - empty = addresses equal and wrap bits equal.
  - The address wraps from DEPTH-1 to 0 and the wrap bit toggles at that point.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en_i & ~full_o
  - rd_acc = rd_en_i & ~empty_o
- Simultaneous events: no bypass. A read from an empty FIFO is rejected even with a concurrent write. A write to a full FIFO is rejected even with a concurrent read; the accepted read still completes.
- Simultaneous accepted read and write: both pointers advance and count_o is unchanged.
- count_o next value = count_o + wr_acc - rd_acc.
- Flag timing: full_o, empty_o, almost_full_o, almost_empty_o and count_o are registered. They reflect post-edge occupancy in the same cycle the pointers change, with no extra-cycle lag.
- Errors:
  - wr_error_o = 1 for exactly the cycle after an edge where wr_en_i & full_o; otherwise 0.
  - rd_error_o = 1 for exactly the cycle after an edge where rd_en_i & empty_o; otherwise 0.
  - A rejected request does not change any state besides its error pulse.
- FWFT=0 (standard mode):
  - rdata_o is a register loaded with mem[rd_ptr] on rd_acc, giving a read latency of 1 cycle.
  - rdata_o holds its value otherwise, including on a rejected read.
- FWFT=1 (first-word-fall-through mode):
  - rdata_o = mem[rd_ptr] combinationally whenever empty_o=0, and 0 when empty_o=1.
  - A word written into an empty FIFO appears on rdata_o in the cycle after the write edge, together with empty_o falling.
  - rd_acc advances to the next word, which is visible right after that edge.
- Ordering: strict first-in first-out with no loss or duplication across any number of pointer wraps.

Test Plan:
- Defaults, reset then idle -> empty_o=1, almost_empty_o=1, count_o=0, rdata_o=0, full_o=0, no error pulses.
- FWFT=0: write 0x01..0x10 over 16 cycles -> full_o=1 and count_o=16 after the 16th edge; almost_full_o=1 from count 14. Then read 16 -> rdata_o=0x01..0x10, one cycle after each read; empty_o=1 after the last read.
- Full FIFO: wr_en_i=1 with wdata_i=0xAA -> wr_error_o pulses one cycle, count_o stays 16, 0xAA is never read. Empty FIFO: rd_en_i=1 -> rd_error_o pulses and rdata_o is unchanged.
- Count 5: simultaneous write and read for 40 cycles -> count_o stays 5, pointers wrap at least twice, output order matches a scoreboard.
- FWFT=1: write 0x3C into an empty FIFO -> next cycle empty_o=0, rdata_o=0x3C with no read issued. rd_en_i=1 -> empty_o=1 and rdata_o=0.
- Count 9 mid-stream: clr_ni=0 for one edge while wr_en_i=rd_en_i=1 -> count_o=0, empty_o=1, no error pulses. The first word written afterwards is the first word read.
